// File: rtl/imem_arbiter_if.sv
// Bus bundle between the fetch stage, the program loader, the arbiter and the
// single-port instruction memory.
interface imem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_gnt;
  logic                  fetch_rvalid;
  logic [DATA_WIDTH-1:0] fetch_rdata;

  logic                  load_req;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_wdata;
  logic                  load_lock;
  logic                  load_gnt;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_gnt, fetch_rvalid, fetch_rdata,
    input  load_req, load_addr, load_wdata, load_lock,
    output load_gnt,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_gnt, fetch_rvalid, fetch_rdata,
    output load_req, load_addr, load_wdata, load_lock,
    input  load_gnt,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Fetch-priority arbiter for the shared instruction memory port, with loader
// starvation guard and a burst lock for multi-word loader writes.
module imem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          rst_n,
    imem_arbiter_if.slave bus
);

    typedef enum logic {ARB, BURST} state_t;

    state_t                state;
    logic [3:0]            starve_cnt;
    logic                  rvalid_q;
    logic                  fetch_gnt;
    logic                  load_gnt;
    logic                  starved;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    assign starved = (starve_cnt == 4'(STARVE_LIMIT));

    // Grants are held low while reset is asserted, independent of state.
    always_comb begin
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        if (rst_n) begin
            if (state == BURST) begin
                load_gnt = bus.load_req;
            end else if (bus.load_req && (!bus.fetch_req || starved)) begin
                load_gnt = 1'b1;
            end else begin
                fetch_gnt = bus.fetch_req;
            end
        end
    end

    assign sel_addr  = load_gnt ? bus.load_addr : bus.fetch_addr;
    assign sel_wdata = bus.load_wdata;

    assign bus.fetch_gnt    = fetch_gnt;
    assign bus.load_gnt     = load_gnt;
    assign bus.mem_en       = fetch_gnt | load_gnt;
    assign bus.mem_we       = load_gnt;
    assign bus.mem_addr     = sel_addr;
    assign bus.mem_wdata    = sel_wdata;
    assign bus.fetch_rvalid = rvalid_q;
    assign bus.fetch_rdata  = bus.mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB;
            starve_cnt <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            rvalid_q <= bus.fetch_req && fetch_gnt;
            if (load_gnt) begin
                starve_cnt <= '0;
                // load_lock only matters on a granted beat; it picks the next state.
                state      <= bus.load_lock ? BURST : ARB;
            end else if (bus.load_req && !starved) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed test of imem_arbiter against a registered-read memory model.
module tb_imem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic preload;
    logic [63:0] mem [0:1023];
    logic [63:0] rdq;
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) bus ();

    imem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .STARVE_LIMIT(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Instruction memory: registered read, plain write, word = address at boot.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 64'(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            rdq <= mem[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rdq;

    task automatic idle_inputs();
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.load_req   = 1'b0;
        bus.load_addr  = '0;
        bus.load_wdata = '0;
        bus.load_lock  = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        preload = 1'b1;
        idle_inputs();
        bus.fetch_req = 1'b1;
        @(negedge clk);
        total_cnt++; if (bus.fetch_gnt !== 1'b0) $display("FAIL reset_fetch_gnt: got %b want 0", bus.fetch_gnt); else pass_cnt++;
        total_cnt++; if (bus.mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b want 0", bus.mem_en); else pass_cnt++;
        total_cnt++; if (bus.fetch_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", bus.fetch_rvalid); else pass_cnt++;
        total_cnt++; if (dut.starve_cnt !== 4'd0) $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt); else pass_cnt++;
        #2;
        rst_n   = 1'b1;
        preload = 1'b0;
        bus.fetch_req = 1'b0;
    endtask

    task automatic test_fetch_stream();
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            bus.fetch_req  = (k < 4);
            bus.fetch_addr = 10'(k);
            @(negedge clk);
            if (k < 4) begin
                total_cnt++; if (bus.fetch_gnt !== 1'b1) $display("FAIL stream_gnt%0d: got %b want 1", k, bus.fetch_gnt); else pass_cnt++;
            end
            if (k > 0) begin
                total_cnt++; if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== 64'(k - 1))
                    $display("FAIL stream_rdata%0d: got v=%b d=%0h want v=1 d=%0h", k, bus.fetch_rvalid, bus.fetch_rdata, k - 1); else pass_cnt++;
            end
        end
    endtask

    task automatic test_single_write();
        next_cycle();
        idle_inputs();
        bus.load_req   = 1'b1;
        bus.load_addr  = 10'd10;
        bus.load_wdata = 64'h1234;
        @(negedge clk);
        total_cnt++; if (bus.load_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd10)
            $display("FAIL write_port: got gnt=%b we=%b addr=%0d want 1 1 10", bus.load_gnt, bus.mem_we, bus.mem_addr); else pass_cnt++;
        next_cycle();
        idle_inputs();
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 10'd10;
        @(negedge clk);
        total_cnt++; if (bus.fetch_gnt !== 1'b1) $display("FAIL raw_gnt: got %b want 1", bus.fetch_gnt); else pass_cnt++;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        total_cnt++; if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== 64'h1234)
            $display("FAIL raw_rdata: got v=%b d=%0h want v=1 d=1234", bus.fetch_rvalid, bus.fetch_rdata); else pass_cnt++;
    endtask

    task automatic test_starvation();
        next_cycle();
        idle_inputs();
        bus.fetch_req  = 1'b1;
        bus.load_req   = 1'b1;
        bus.load_addr  = 10'd20;
        bus.load_wdata = 64'hAA;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            total_cnt++; if (dut.starve_cnt !== 4'(c - 1)) $display("FAIL starve_cnt%0d: got %0d want %0d", c, dut.starve_cnt, c - 1); else pass_cnt++;
            total_cnt++; if (bus.load_gnt !== (c == 5) || bus.fetch_gnt !== (c != 5))
                $display("FAIL starve_gnt%0d: got load=%b fetch=%b want load=%b fetch=%b", c, bus.load_gnt, bus.fetch_gnt, c == 5, c != 5); else pass_cnt++;
            if (c < 5) next_cycle();
        end
        next_cycle();
        bus.load_req = 1'b0;
        @(negedge clk);
        total_cnt++; if (bus.fetch_gnt !== 1'b1 || dut.starve_cnt !== 4'd0 || bus.fetch_rvalid !== 1'b0)
            $display("FAIL starve_after: got gnt=%b cnt=%0d rvalid=%b want 1 0 0", bus.fetch_gnt, dut.starve_cnt, bus.fetch_rvalid); else pass_cnt++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_burst();
        bus.load_req = 1'b1; bus.load_addr = 10'd1021; bus.load_wdata = 64'hB0; bus.load_lock = 1'b1;
        @(negedge clk);
        total_cnt++; if (bus.load_gnt !== 1'b1) $display("FAIL burst_beat0: got %b want 1", bus.load_gnt); else pass_cnt++;
        next_cycle();
        bus.fetch_req = 1'b1; bus.fetch_addr = 10'd1021;
        bus.load_addr = 10'd1022; bus.load_wdata = 64'hB1;
        @(negedge clk);
        total_cnt++; if (bus.load_gnt !== 1'b1 || bus.fetch_gnt !== 1'b0)
            $display("FAIL burst_beat1: got load=%b fetch=%b want 1 0", bus.load_gnt, bus.fetch_gnt); else pass_cnt++;
        next_cycle();
        bus.load_req = 1'b0;
        @(negedge clk);
        total_cnt++; if (bus.fetch_gnt !== 1'b0 || bus.mem_en !== 1'b0)
            $display("FAIL burst_gap: got fetch=%b en=%b want 0 0", bus.fetch_gnt, bus.mem_en); else pass_cnt++;
        next_cycle();
        bus.load_req = 1'b1; bus.load_addr = 10'd1023; bus.load_wdata = 64'hB2; bus.load_lock = 1'b0;
        @(negedge clk);
        total_cnt++; if (bus.load_gnt !== 1'b1 || bus.fetch_gnt !== 1'b0)
            $display("FAIL burst_beat2: got load=%b fetch=%b want 1 0", bus.load_gnt, bus.fetch_gnt); else pass_cnt++;
        next_cycle();
        bus.load_req = 1'b0; bus.load_lock = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next_cycle();
            bus.fetch_req  = (k < 3);
            bus.fetch_addr = 10'(1021 + k);
            @(negedge clk);
            if (k < 3) begin
                total_cnt++; if (bus.fetch_gnt !== 1'b1) $display("FAIL burst_readback_gnt%0d: got %b want 1", k, bus.fetch_gnt); else pass_cnt++;
            end
            if (k > 0) begin
                total_cnt++; if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== 64'hB0 + 64'(k - 1))
                    $display("FAIL burst_readback%0d: got v=%b d=%0h want v=1 d=%0h", k, bus.fetch_rvalid, bus.fetch_rdata, 64'hB0 + 64'(k - 1)); else pass_cnt++;
            end
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        bus.fetch_req = 1'b1; bus.fetch_addr = 10'd3;
        bus.load_req  = 1'b1; bus.load_addr  = 10'd30; bus.load_wdata = 64'hCC;
        @(negedge clk);
        total_cnt++; if (bus.fetch_gnt !== 1'b1 || bus.load_gnt !== 1'b0)
            $display("FAIL simul_gnt: got fetch=%b load=%b want 1 0", bus.fetch_gnt, bus.load_gnt); else pass_cnt++;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        total_cnt++; if (dut.starve_cnt !== 4'd1) $display("FAIL simul_starve: got %0d want 1", dut.starve_cnt); else pass_cnt++;
        total_cnt++; if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== 64'd3)
            $display("FAIL simul_rdata: got v=%b d=%0h want v=1 d=3", bus.fetch_rvalid, bus.fetch_rdata); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        bus.load_req = 1'b1; bus.load_addr = 10'd100; bus.load_wdata = 64'h55; bus.load_lock = 1'b1;
        @(negedge clk);
        total_cnt++; if (bus.load_gnt !== 1'b1) $display("FAIL rstb_beat0: got %b want 1", bus.load_gnt); else pass_cnt++;
        next_cycle();
        bus.load_addr = 10'd101; bus.load_wdata = 64'h66;
        bus.fetch_req = 1'b1; bus.fetch_addr = 10'd2;
        @(negedge clk);
        total_cnt++; if (bus.load_gnt !== 1'b1 || bus.fetch_gnt !== 1'b0)
            $display("FAIL rstb_beat1: got load=%b fetch=%b want 1 0", bus.load_gnt, bus.fetch_gnt); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.load_gnt !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0)
            $display("FAIL rstb_forced: got gnt=%b en=%b we=%b want 0 0 0", bus.load_gnt, bus.mem_en, bus.mem_we); else pass_cnt++;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (bus.fetch_gnt !== 1'b1 || bus.load_gnt !== 1'b0 || bus.fetch_rvalid !== 1'b0)
            $display("FAIL rstb_arb: got fetch=%b load=%b rvalid=%b want 1 0 0", bus.fetch_gnt, bus.load_gnt, bus.fetch_rvalid); else pass_cnt++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_during_fetch();
        bus.fetch_req = 1'b1; bus.fetch_addr = 10'd0;
        @(negedge clk);
        total_cnt++; if (bus.fetch_gnt !== 1'b1) $display("FAIL rstf_gnt: got %b want 1", bus.fetch_gnt); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.fetch_gnt !== 1'b0 || bus.mem_en !== 1'b0)
            $display("FAIL rstf_forced: got gnt=%b en=%b want 0 0", bus.fetch_gnt, bus.mem_en); else pass_cnt++;
        next_cycle();
        total_cnt++; if (bus.fetch_rvalid !== 1'b0) $display("FAIL rstf_rvalid: got %b want 0", bus.fetch_rvalid); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (bus.fetch_gnt !== 1'b1) $display("FAIL rstf_release_gnt: got %b want 1", bus.fetch_gnt); else pass_cnt++;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        total_cnt++; if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== 64'd0)
            $display("FAIL rstf_rdata: got v=%b d=%0h want v=1 d=0", bus.fetch_rvalid, bus.fetch_rdata); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fetch_stream();
        test_single_write();
        test_starvation();
        test_burst();
        test_simultaneous();
        test_reset_mid_burst();
        test_reset_during_fetch();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-port 1024×64 instruction memory between two requesters: the fetch stage reads instructions, and the program loader writes instructions at boot or in debug. Fetch has priority. A starvation counter guarantees loader progress, and a burst lock gives the loader exclusive access for multi-word writes. The block sits between the PC/fetch logic, the loader and the instruction memory, which is modified to a registered (1-cycle) read with write enable.

## Interface
- ADDR_WIDTH, 10, memory address width (1024 locations)
- DATA_WIDTH, 64, instruction width
- STARVE_LIMIT, 4, consecutive denied loader cycles before the loader is forced priority (range 1–15)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- fetch_req  in  1  fetch read request
- fetch_addr  in  ADDR_WIDTH  fetch address
- fetch_gnt  out  1  fetch request accepted this cycle
- fetch_rvalid  out  1  fetch_rdata valid (one cycle after grant)
- fetch_rdata  out  DATA_WIDTH  instruction read
- load_req  in  1  loader write request
- load_addr  in  ADDR_WIDTH  write address
- load_wdata  in  DATA_WIDTH  write data
- load_lock  in  1  with a granted write: hold exclusive access for the next beat
- load_gnt  out  1  write accepted this cycle
- mem_en, mem_we  out  1 each  memory access enable / write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read

## Operation
- Transfer: req && gnt in the same cycle. A requester holds req/addr/data stable until granted.
- Grants are combinational from the current inputs and registered state. At most one grant per cycle.
- Memory port mirrors the granted requester:
  - mem_en = fetch_gnt | load_gnt
  - mem_we = load_gnt
  - mem_addr and mem_wdata come from the winner. mem_wdata is don't-care on reads; drive load_wdata.
- State ARB:
  - Fetch wins when both request, unless starve_cnt == STARVE_LIMIT; then the loader wins.
  - A sole requester always wins.
- State BURST: the loader has exclusive access.
  - fetch_gnt = 0.
  - load_gnt = load_req.
  - An idle loader (load_req = 0) stays in BURST with the memory idle.
- State transitions:
  - ARB→BURST on a granted write with load_lock = 1.
  - BURST→ARB on a granted write with load_lock = 0 (last beat).
  - BURST→BURST on a granted write with load_lock = 1.
- starve_cnt (4-bit):
  - Increments each cycle load_req && !load_gnt, saturating at STARVE_LIMIT.
  - Clears on any load_gnt.
  - Holds when load_req = 0.
- Read return:
  - fetch_rvalid is a register set to the value of (fetch_req && fetch_gnt).
  - fetch_rdata = mem_rdata, passed through combinationally.
- Read-after-write to the same address in consecutive cycles returns the new data (memory write-first is not required; writes and reads never share a cycle).

## Timing
- Reset values: state ARB, starve_cnt 0, fetch_rvalid 0. While rst_n is low, fetch_gnt, load_gnt, mem_en and mem_we are forced to 0.
- Asynchronous assert; synchronous-release timing is provided externally.
- Grant latency is 0 cycles. Fetch data latency is 1 cycle (gnt at T, rvalid/rdata at T+1).
- Fetch throughput: one read per cycle when the loader is idle.
- Loader worst-case wait in ARB under continuous fetch: STARVE_LIMIT cycles. It is granted in cycle STARVE_LIMIT+1 of requesting.
- After a forced loader grant, starve_cnt = 0, so fetch regains priority next cycle.
- Reset mid-burst: returns to ARB. fetch_rvalid for a read granted in the reset cycle is dropped (it stays 0).
- load_lock is sampled only on a granted beat. It is ignored otherwise.

## Test plan
- Fetch only, addresses 0,1,2,3 back-to-back, memory preloaded with word = address → fetch_gnt = 1 every cycle; fetch_rvalid from cycle 2 with rdata 0,1,2,3.
- Single write 0x1234 to address 10 from the loader, fetch idle; then fetch address 10 → load_gnt at T; mem_we = 1, mem_addr = 10; rdata 0x1234 at T+2.
- Continuous fetch plus a held loader request with STARVE_LIMIT = 4 → load_gnt low for 4 cycles, high on the 5th with fetch_gnt = 0; fetch granted again the next cycle; starve_cnt back to 0.
- 3-beat burst (lock = 1,1,0) to addresses 1021, 1022, 1023 under continuous fetch requests → fetch_gnt = 0 from the first load grant through the final beat; loader idle gap mid-burst still blocks fetch; ARB resumes after beat 3; memory holds all three words.
- rst_n pulled low mid-burst and during a fetch grant → outputs/grants 0 immediately; fetch_rvalid 0 the next cycle; after release fetch is granted in ARB.
- Simultaneous fetch and loader request with starve_cnt = 0 → fetch wins; starve_cnt = 1 next cycle.
